// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings, state type and byte-enable helpers for dmem_access_ctrl.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  // Low nibble is the first word's enables, high nibble spills into the next word.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    m = be_mask(size, off);
    return |m[7:4];
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lsu_align.sv
// Combinational lane steering: store data shift across two words, load byte
// extraction from up to two words, and sign/zero extension.
module lsu_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_lo_o,
  output logic [31:0] st_hi_o,
  input  logic [31:0] ld_lo_i,
  input  logic [23:0] ld_hi_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  always_comb begin
    st_lo_o  = st_data_i;
    st_hi_o  = '0;
    ld_shift = ld_lo_i;
    case (off_i)
      2'd1: begin
        st_lo_o  = {st_data_i[23:0], 8'h00};
        st_hi_o  = {24'h0, st_data_i[31:24]};
        ld_shift = {ld_hi_i[7:0], ld_lo_i[31:8]};
      end
      2'd2: begin
        st_lo_o  = {st_data_i[15:0], 16'h0000};
        st_hi_o  = {16'h0, st_data_i[31:16]};
        ld_shift = {ld_hi_i[15:0], ld_lo_i[31:16]};
      end
      2'd3: begin
        st_lo_o  = {st_data_i[7:0], 24'h000000};
        st_hi_o  = {8'h0, st_data_i[31:8]};
        ld_shift = {ld_hi_i[23:0], ld_lo_i[31:24]};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: ld_data_o = {{24{signed_i & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data_o = {{16{signed_i & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer with word-addressed req/ack port.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses into two words.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; stall asserted combinationally on accept
// ACC0  | first (or only) word request outstanding
// ACC1  | second word of a split access outstanding
// DONE  | one-cycle completion: done pulse, rdata valid, err if failed
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      size,
  input  logic            load_signed,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = ACK_TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam bit              TO_EN    = (ACK_TIMEOUT != 0);

  dmem_state_t       state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word0_q, word0_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req;
  logic [7:0]        be_all;
  logic [31:0]       word_base;
  logic [31:0]       st_lo, st_hi, ld_lo, ld_data;

  assign req       = mem_read | mem_write;
  assign be_all    = be_mask(size_q, addr_q[1:0]);
  assign word_base = {addr_q[31:2], 2'b00};
  // The second word of a split load arrives after the first has been captured.
  assign ld_lo     = (state_q == ACC1) ? word0_q : dmem_rdata;

  lsu_align u_align (
    .off_i     (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .st_data_i (wdata_q),
    .st_lo_o   (st_lo),
    .st_hi_o   (st_hi),
    .ld_lo_i   (ld_lo),
    .ld_hi_i   (dmem_rdata[23:0]),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word0_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word0_q  <= word0_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word0_d    = word0_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall    = 1'b1;
          we_d     = mem_write & ~mem_read;
          size_d   = size;
          signed_d = load_signed;
          addr_d   = addr;
          wdata_d  = wdata;
          err_d    = 1'b0;
          cnt_d    = CNT_LOAD;
          state_d  = ACC0;
`ifndef DMEM_MISALIGN_SPLIT_EN
          if (is_misaligned(size, addr[1:0])) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end

      ACC0, ACC1: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = we_q;
        if (state_q == ACC0) begin
          dmem_addr  = word_base;
          dmem_be    = be_all[3:0];
          dmem_wdata = st_lo;
        end else begin
          dmem_addr  = word_base + 32'd4;
          dmem_be    = be_all[7:4];
          dmem_wdata = st_hi;
        end

        if (dmem_ack) begin
          cnt_d   = CNT_LOAD;
          word0_d = dmem_rdata;
          rdata_d = we_q ? '0 : ld_data;
          state_d = DONE;
`ifdef DMEM_MISALIGN_SPLIT_EN
          if ((state_q == ACC0) && (|be_all[7:4])) state_d = ACC1;
`endif
        end else if (TO_EN && (cnt_q == CNT_ONE)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (TO_EN) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign done  = (state_q == DONE);
  assign err   = (state_q == DONE) & err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (ACK_TIMEOUT = 4).
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, load_signed;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, done, err, dmem_req, dmem_we, dmem_ack;
  logic [31:0] rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  // observations from the most recent run_access
  logic        obs_done, obs_err, obs_unstable;
  logic [31:0] obs_rdata;
  int          obs_lat, obs_stalls, obs_req, obs_nacc, obs_writes;
  logic [31:0] o_addr [2];
  logic [3:0]  o_be   [2];
  logic [31:0] o_wd   [2];
  logic        o_we   [2];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_signed(load_signed), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .err(err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one access and a memory responder; ack_delay < 0 means never ack.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_delay, input logic [31:0] rd0, input logic [31:0] rd1);
    int  waitc;
    int  nword;
    bit  acked, was_req;
    obs_done = 0; obs_err = 0; obs_rdata = '0; obs_lat = -1; obs_stalls = 0;
    obs_req = 0; obs_nacc = 0; obs_writes = 0; obs_unstable = 0;
    for (int k = 0; k < 2; k++) begin
      o_addr[k] = 'x; o_be[k] = 'x; o_wd[k] = 'x; o_we[k] = 1'bx;
    end
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; load_signed = sg; addr = a; wdata = wd;
    dmem_ack = 0;
    waitc = 0; nword = 0;
    for (int cyc = 0; cyc < 60 && !obs_done; cyc++) begin
      #1;
      acked = 0; was_req = 0;
      if (stall) obs_stalls++;
      if (done) begin
        obs_done = 1; obs_err = err; obs_rdata = rdata; obs_lat = cyc;
        mem_read = 0; mem_write = 0;
      end else if (dmem_req) begin
        was_req = 1;
        obs_req++;
        if (waitc == 0 && nword < 2) begin
          o_addr[nword] = dmem_addr; o_be[nword] = dmem_be;
          o_wd[nword] = dmem_wdata; o_we[nword] = dmem_we;
          obs_nacc++;
        end else if (nword < 2) begin
          if (o_addr[nword] !== dmem_addr || o_be[nword] !== dmem_be ||
              o_wd[nword] !== dmem_wdata || o_we[nword] !== dmem_we)
            obs_unstable = 1;
        end
        if (ack_delay >= 0 && waitc >= ack_delay) begin
          dmem_ack = 1;
          dmem_rdata = (nword == 0) ? rd0 : rd1;
          acked = 1;
          if (dmem_we) obs_writes++;
        end
      end
      @(negedge clk);
      dmem_ack = 0;
      if (acked) begin nword++; waitc = 0; end
      else if (was_req) waitc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 0; mem_read = 0; mem_write = 0; size = 0; load_signed = 0;
    addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({stall, done, err, dmem_req, dmem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {stall, done, err, dmem_req, dmem_we});
    end
    checks++;
    if ({rdata, dmem_addr, dmem_be, dmem_wdata} !== 100'b0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%h be=%h wdata=%h expected all 0",
                         rdata, dmem_addr, dmem_be, dmem_wdata);
    end
    rst_n = 1;
  endtask

  task automatic test_lw_aligned;
    run_access(1, 0, 2'b00, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0);
    checks++;
    if ({o_addr[0], o_be[0], o_we[0]} !== {32'h100, 4'hF, 1'b0}) begin
      errors++; $display("FAIL lw_req: addr=%h be=%h we=%b expected 00000100 f 0", o_addr[0], o_be[0], o_we[0]);
    end
    checks++;
    if ({obs_done, obs_err, obs_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw_result: done=%b err=%b rdata=%h expected 1 0 deadbeef", obs_done, obs_err, obs_rdata);
    end
    checks++;
    if (obs_lat !== 2 || obs_stalls !== 2 || obs_nacc !== 1) begin
      errors++; $display("FAIL lw_latency: lat=%0d stalls=%0d nacc=%0d expected 2 2 1", obs_lat, obs_stalls, obs_nacc);
    end
    #1;
    checks++;
    if ({done, stall} !== 2'b00) begin
      errors++; $display("FAIL lw_done_pulse: done=%b stall=%b expected 0 0", done, stall);
    end
  endtask

  task automatic test_loads_sub;
    run_access(1, 0, 2'b10, 1, 32'h103, 0, 0, 32'h80FFFFFF, 0);
    checks++;
    if ({o_be[0], obs_rdata, obs_err} !== {4'h8, 32'hFFFFFF80, 1'b0}) begin
      errors++; $display("FAIL lb_signed: be=%h rdata=%h err=%b expected 8 ffffff80 0", o_be[0], obs_rdata, obs_err);
    end
    run_access(1, 0, 2'b10, 0, 32'h103, 0, 0, 32'h80FFFFFF, 0);
    checks++;
    if ({o_be[0], obs_rdata} !== {4'h8, 32'h00000080}) begin
      errors++; $display("FAIL lbu: be=%h rdata=%h expected 8 00000080", o_be[0], obs_rdata);
    end
    run_access(1, 0, 2'b01, 1, 32'h102, 0, 1, 32'h80012345, 0);
    checks++;
    if ({o_be[0], obs_rdata, obs_lat} !== {4'hC, 32'hFFFF8001, 32'd3}) begin
      errors++; $display("FAIL lh_signed: be=%h rdata=%h lat=%0d expected c ffff8001 3", o_be[0], obs_rdata, obs_lat);
    end
    run_access(1, 0, 2'b01, 0, 32'h100, 0, 0, 32'h1234F00D, 0);
    checks++;
    if ({o_be[0], obs_rdata} !== {4'h3, 32'h0000F00D}) begin
      errors++; $display("FAIL lhu: be=%h rdata=%h expected 3 0000f00d", o_be[0], obs_rdata);
    end
  endtask

  task automatic test_stores;
    run_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 0, 0, 0);
    checks++;
    if ({o_addr[0], o_be[0], o_wd[0], o_we[0]} !== {32'h200, 4'hC, 32'hABCD0000, 1'b1}) begin
      errors++; $display("FAIL sh: addr=%h be=%h wdata=%h we=%b expected 00000200 c abcd0000 1",
                         o_addr[0], o_be[0], o_wd[0], o_we[0]);
    end
    checks++;
    if (obs_nacc !== 1 || obs_writes !== 1 || obs_err !== 0 || obs_done !== 1) begin
      errors++; $display("FAIL sh_single: nacc=%0d writes=%0d err=%b done=%b expected 1 1 0 1",
                         obs_nacc, obs_writes, obs_err, obs_done);
    end
    // mem_read wins when both request lines are high
    run_access(1, 1, 2'b10, 0, 32'h201, 32'h0000005A, 0, 32'h0000A500, 0);
    checks++;
    if ({o_we[0], o_be[0], obs_rdata} !== {1'b0, 4'h2, 32'h000000A5}) begin
      errors++; $display("FAIL read_wins: we=%b be=%h rdata=%h expected 0 2 000000a5", o_we[0], o_be[0], obs_rdata);
    end
    run_access(0, 1, 2'b10, 0, 32'h201, 32'h0000005A, 0, 0, 0);
    checks++;
    if ({o_be[0], o_wd[0], o_we[0]} !== {4'h2, 32'h00005A00, 1'b1}) begin
      errors++; $display("FAIL sb: be=%h wdata=%h we=%b expected 2 00005a00 1", o_be[0], o_wd[0], o_we[0]);
    end
  endtask

  task automatic test_misaligned;
    run_access(0, 1, 2'b00, 0, 32'h101, 32'h11223344, 0, 0, 0);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++;
    if ({o_addr[0], o_be[0], o_wd[0], o_addr[1], o_be[1], o_wd[1]} !==
        {32'h100, 4'hE, 32'h22334400, 32'h104, 4'h1, 32'h00000011}) begin
      errors++; $display("FAIL sw_split: a0=%h be0=%h wd0=%h a1=%h be1=%h wd1=%h expected 100 e 22334400 104 1 00000011",
                         o_addr[0], o_be[0], o_wd[0], o_addr[1], o_be[1], o_wd[1]);
    end
    checks++;
    if (obs_err !== 0 || obs_done !== 1 || obs_lat !== 3 || obs_writes !== 2) begin
      errors++; $display("FAIL sw_split_done: err=%b done=%b lat=%0d writes=%0d expected 0 1 3 2",
                         obs_err, obs_done, obs_lat, obs_writes);
    end
    run_access(1, 0, 2'b00, 0, 32'h102, 0, 0, 32'hAABBCCDD, 32'h11223344);
    checks++;
    if ({obs_rdata, obs_err, obs_nacc} !== {32'h3344AABB, 1'b0, 32'd2}) begin
      errors++; $display("FAIL lw_split: rdata=%h err=%b nacc=%0d expected 3344aabb 0 2", obs_rdata, obs_err, obs_nacc);
    end
    run_access(1, 0, 2'b01, 1, 32'hFFFFFFFF, 0, 0, 32'h7F000000, 32'h000000C3);
    checks++;
    if ({o_addr[0], o_be[0], o_addr[1], o_be[1], obs_rdata} !==
        {32'hFFFFFFFC, 4'h8, 32'h00000000, 4'h1, 32'hFFFFC37F}) begin
      errors++; $display("FAIL lh_wrap: a0=%h be0=%h a1=%h be1=%h rdata=%h expected fffffffc 8 00000000 1 ffffc37f",
                         o_addr[0], o_be[0], o_addr[1], o_be[1], obs_rdata);
    end
`else
    checks++;
    if ({obs_done, obs_err, obs_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL sw_misaligned: done=%b err=%b rdata=%h expected 1 1 00000000", obs_done, obs_err, obs_rdata);
    end
    checks++;
    if (obs_req !== 0 || obs_stalls !== 1 || obs_lat !== 1) begin
      errors++; $display("FAIL sw_misaligned_noreq: req=%0d stalls=%0d lat=%0d expected 0 1 1", obs_req, obs_stalls, obs_lat);
    end
    run_access(1, 0, 2'b01, 1, 32'hFFFFFFFF, 0, 0, 32'h7F000000, 32'h000000C3);
    checks++;
    if ({obs_done, obs_err, obs_rdata, 32'(obs_req)} !== {1'b1, 1'b1, 32'h0, 32'd0}) begin
      errors++; $display("FAIL lh_misaligned: done=%b err=%b rdata=%h req=%0d expected 1 1 0 0",
                         obs_done, obs_err, obs_rdata, obs_req);
    end
`endif
  endtask

  task automatic test_timeout;
    run_access(1, 0, 2'b00, 0, 32'h300, 0, -1, 32'h55555555, 0);
    checks++;
    if ({obs_done, obs_err, obs_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_result: done=%b err=%b rdata=%h expected 1 1 00000000", obs_done, obs_err, obs_rdata);
    end
    checks++;
    if (obs_lat !== 5 || obs_req !== 4 || obs_unstable !== 0) begin
      errors++; $display("FAIL timeout_timing: lat=%0d req=%0d unstable=%b expected 5 4 0", obs_lat, obs_req, obs_unstable);
    end
    #1;
    checks++;
    if ({done, err, stall, dmem_req} !== 4'b0000) begin
      errors++; $display("FAIL timeout_idle: done=%b err=%b stall=%b req=%b expected 0000", done, err, stall, dmem_req);
    end
    // ack on the last allowed wait cycle beats the timeout
    run_access(1, 0, 2'b00, 0, 32'h304, 0, 3, 32'h12345678, 0);
    checks++;
    if ({obs_done, obs_err, obs_rdata, 32'(obs_lat)} !== {1'b1, 1'b0, 32'h12345678, 32'd5}) begin
      errors++; $display("FAIL ack_beats_timeout: done=%b err=%b rdata=%h lat=%0d expected 1 0 12345678 5",
                         obs_done, obs_err, obs_rdata, obs_lat);
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    mem_read = 1; mem_write = 0; size = 2'b00; addr = 32'h400; dmem_ack = 0;
    @(negedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_acc0: dmem_req=%b expected 1", dmem_req);
    end
    rst_n = 0; mem_read = 0;
    @(negedge clk); #1;
    checks++;
    if ({dmem_req, stall, done, err} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_abandon: req=%b stall=%b done=%b err=%b expected 0000", dmem_req, stall, done, err);
    end
    rst_n = 1;
    run_access(1, 0, 2'b00, 0, 32'h404, 0, 0, 32'hCAFEF00D, 0);
    checks++;
    if ({obs_done, obs_err, obs_rdata, 32'(obs_lat), o_addr[0]} !==
        {1'b1, 1'b0, 32'hCAFEF00D, 32'd2, 32'h404}) begin
      errors++; $display("FAIL rst_then_lw: done=%b err=%b rdata=%h lat=%0d addr=%h expected 1 0 cafef00d 2 404",
                         obs_done, obs_err, obs_rdata, obs_lat, o_addr[0]);
    end
  endtask

  initial begin
    test_reset();
    test_lw_aligned();
    test_loads_sub();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the RV32I pipeline.
- Takes MemRead/MemWrite, LoadSize and LoadSigned from the main decoder plus the ALU address and store data.
- Drives a word-addressed req/ack data-memory port with byte enables, and returns aligned, sign/zero-extended load data.
- Stalls the pipeline until each access completes.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported)
- ACK_TIMEOUT, 255, ack-wait cycles before err asserts (0 = never time out)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- mem_read  in  1  load request from MEM stage
- mem_write  in  1  store request from MEM stage
- size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- load_signed  in  1  1 = sign-extend, 0 = zero-extend (loads only)
- addr  in  XLEN  byte address
- wdata  in  XLEN  store data, LSB-aligned
- stall  out  1  hold the pipeline
- rdata  out  XLEN  extended load result
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse (misaligned or timeout)
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  XLEN  word-aligned address, bits[1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  XLEN  read word

Behaviour:
- Reset values (rst_n low at a clk edge): state IDLE; stall, done, err, dmem_req and dmem_we at 0; rdata, dmem_addr, dmem_be and dmem_wdata at 0.
- Reset mid-access abandons the access; dmem_req is low from the next cycle.
- FSM states are IDLE, ACC0, ACC1, DONE.
- IDLE:
  - A request is mem_read|mem_write; mem_read wins if both are high.
  - On a request, latch all inputs, assert stall combinationally in the same cycle, and go to ACC0.
- ACC0:
  - dmem_req=1, dmem_we=latched write, dmem_addr=addr&~3.
  - Hold all dmem_* outputs stable until dmem_ack.
  - On ack: go to ACC1 if the access is split, else DONE.
- ACC1:
  - Second word at (addr&~3)+4; wraps modulo 2^32.
  - On ack, go to DONE.
- DONE:
  - stall=0, done=1 and rdata valid for exactly one cycle, then IDLE.
  - The request inputs present in DONE are the completed op and are not re-accepted.
- stall=1 in IDLE-with-request, ACC0 and ACC1; otherwise 0.
- Minimum latency with ack in the first ACC cycle: 3 cycles from request to done (2 stall cycles).
- Byte enables, with off=addr[1:0]:
  - byte: 1<<off
  - half: 3<<off
  - word: 4'hF<<off
  - Bits above 3 spill into the ACC1 enables (split case only).
- Store data:
  - dmem_wdata = wdata<<(8*off) for ACC0.
  - dmem_wdata = wdata>>(8*(4-off)) for ACC1.
- Load data:
  - Extract bytes from ACC0 (and ACC1) rdata, right-align, then extend to 32 bits per load_signed.
  - Word loads ignore load_signed.
- Misaligned cases: half with off=3, or word with off≠0.
- Timeout:
  - If ACK_TIMEOUT≠0 and ACK_TIMEOUT cycles elapse in ACC0 or ACC1 without ack, go to DONE with err=1 and rdata=0.
  - The counter resets on each ack.
- Simultaneous ack and timeout expiry in the same cycle: ack wins.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: a misaligned access is split into ACC0+ACC1 as above; err stays 0.
- Undefined:
  - A misaligned access goes IDLE→DONE directly with err=1, rdata=0, done=1.
  - No dmem_req is issued and memory is never written; stall is high only in the accept cycle.
  - ACC1 is unreachable.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - size encodings SZ_WORD/SZ_HALF/SZ_BYTE
  - state enum dmem_state_t
  - helper function for the byte-enable mask
- One combinational sub-module, lsu_align: store lane shift, load byte extraction and extension.
- The FSM, latches and timeout counter stay in the top module.

Test Plan:
- Aligned LW addr=0x100, rdata=0xDEADBEEF, ack after 1 cycle -> dmem_addr=0x100, be=F, done with rdata=0xDEADBEEF, 2 stall cycles.
- LB signed addr=0x103, word=0x80FF_FFFF -> be=8, rdata=0xFFFFFF80; same with LBU -> rdata=0x00000080.
- SH addr=0x202, wdata=0x0000ABCD -> be=C, dmem_wdata=0xABCD0000, we=1, single access.
- SW addr=0x101, wdata=0x11223344:
  - With macro: ACC0 be=E, wdata=0x22334400 at 0x100; ACC1 be=1, wdata=0x00000011 at 0x104.
  - Without macro: err=1, no dmem_req.
- No ack for ACK_TIMEOUT=4 cycles -> err and done pulse after the 4th wait cycle, rdata=0, FSM back to IDLE.
- rst_n low while in ACC0 -> next cycle dmem_req=0, stall=0, state IDLE; a new LW then completes normally.
